// File: rtl/control_decoder_pkg.sv
// Shared encodings for the multicycle ARM control decoder: state codes,
// ALU command decode values and datapath mux select encodings.
package control_decoder_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Funct[4:1] command field of data-processing instructions
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/control_decoder_main_fsm.sv
// Moore sequencer for the multicycle datapath: state register plus
// next-state and per-state enable/mux-select decode.
//
// state    | meaning
// ---------+------------------------------------------------
// FETCH    | load IR from memory[PC], PC <= PC + 4
// DECODE   | read registers, precompute PC + 8
// MEMADR   | compute load/store address (base + imm)
// MEMRD    | read data memory at ALUOut
// MEMWB    | write loaded data to Rd
// MEMWR    | write RD2 to data memory at ALUOut
// EXECUTER | data-processing with register operand
// EXECUTEI | data-processing with immediate operand
// ALUWB    | write ALU result to Rd
// BRANCH   | PC <= PC + 8 + offset
// UNKNOWN  | undefined opcode, idle for one cycle
module control_decoder_main_fsm
    import control_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic       imm_flag,
    input  logic       load_flag,
    output logic       RegW,
    output logic       MemW,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       Branch,
    output logic       ALUOp
);

    state_t state, state_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = FETCH;
        RegW       = 1'b0;
        MemW       = 1'b0;
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RD2;
        Branch     = 1'b0;
        ALUOp      = 1'b0;

        case (state)
            FETCH: begin
                state_next = DECODE;
                IRWrite    = 1'b1;
                NextPC     = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
            end
            DECODE: begin
                case (Op)
                    OP_DP:   state_next = imm_flag ? EXECUTEI : EXECUTER;
                    OP_MEM:  state_next = MEMADR;
                    OP_BR:   state_next = BRANCH;
                    default: state_next = UNKNOWN;
                endcase
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            MEMADR: begin
                state_next = load_flag ? MEMRD : MEMWR;
                ALUSrcB    = SRCB_IMM;
            end
            MEMRD: begin
                state_next = MEMWB;
                AdrSrc     = 1'b1;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECUTER: begin
                state_next = ALUWB;
                ALUOp      = 1'b1;
            end
            EXECUTEI: begin
                state_next = ALUWB;
                ALUSrcB    = SRCB_IMM;
                ALUOp      = 1'b1;
            end
            ALUWB: begin
                RegW = 1'b1;
            end
            BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                Branch    = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

endmodule

// File: rtl/control_decoder.sv
// Control unit for the multicycle ARM datapath: main sequencer plus ALU
// decode and the unconditioned enables consumed by the condition logic.
module control_decoder
    import control_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic [1:0] FlagW,
    output logic       PCS,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl
);

    logic branch;
    logic alu_op;
    logic cmd_ok;

    control_decoder_main_fsm u_main_fsm (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .imm_flag  (Funct[5]),
        .load_flag (Funct[0]),
        .RegW      (RegW),
        .MemW      (MemW),
        .IRWrite   (IRWrite),
        .NextPC    (NextPC),
        .AdrSrc    (AdrSrc),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .Branch    (branch),
        .ALUOp     (alu_op)
    );

    // Unsupported commands fall back to ADD with no flag update.
    always_comb begin
        ALUControl = ALU_ADD;
        cmd_ok     = 1'b0;
        FlagW      = 2'b00;
        if (alu_op) begin
            cmd_ok = 1'b1;
            case (Funct[4:1])
                CMD_ADD: ALUControl = ALU_ADD;
                CMD_SUB: ALUControl = ALU_SUB;
                CMD_AND: ALUControl = ALU_AND;
                CMD_ORR: ALUControl = ALU_ORR;
                default: cmd_ok     = 1'b0;
            endcase
            if (cmd_ok) begin
                FlagW[1] = Funct[0];
                FlagW[0] = Funct[0] & ((ALUControl == ALU_ADD) || (ALUControl == ALU_SUB));
            end
        end
    end

    assign PCS    = branch | (RegW & (Rd == 4'hF));
    assign ImmSrc = Op;
    assign RegSrc = {(Op == OP_MEM), (Op == OP_BR)};

endmodule

// File: tb/tb_control_decoder.sv
// Randomized self-checking bench for control_decoder against an
// instruction-level phase model of the multicycle control sequence.
module tb_control_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [1:0] FlagW;
    logic       PCS;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUControl;

    control_decoder dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .ALUControl(ALUControl)
    );

    always #5 clk = ~clk;

    // instruction phases as seen by the model
    localparam int PH_FETCH = 0, PH_DECODE = 1, PH_MEMADR = 2, PH_MEMRD = 3,
                   PH_MEMWB = 4, PH_MEMWR = 5, PH_EXR = 6, PH_EXI = 7,
                   PH_ALUWB = 8, PH_BRANCH = 9, PH_UNK = 10;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_phase = PH_FETCH;
    bit exp_valid = 1'b0;
    int cur_len   = 0;
    int cnt       = 0;
    bit started   = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // {ALUControl, FlagW} for a data-processing Funct field
    function automatic logic [3:0] alu_model(input logic [5:0] f);
        logic [1:0] ctl;
        bit sup;
        sup = 1'b1;
        ctl = 2'd0;
        case (f[4:1])
            4'b0100: ctl = 2'd0;
            4'b0010: ctl = 2'd1;
            4'b0000: ctl = 2'd2;
            4'b1100: ctl = 2'd3;
            default: sup = 1'b0;
        endcase
        if (!sup) return 4'b0000;
        return {ctl, f[0], f[0] & (ctl <= 2'd1)};
    endfunction

    always @(negedge clk) begin
        if (!exp_valid) begin
            started = 1'b0;
        end else begin : cmp
            bit rw, br, ex;
            logic [3:0] am;
            rw = (exp_phase == PH_MEMWB) || (exp_phase == PH_ALUWB);
            br = (exp_phase == PH_BRANCH);
            ex = (exp_phase == PH_EXR) || (exp_phase == PH_EXI);
            am = alu_model(Funct);

            chk("IRWrite", int'(IRWrite), int'(exp_phase == PH_FETCH));
            chk("NextPC",  int'(NextPC),  int'(exp_phase == PH_FETCH));
            chk("RegW",    int'(RegW),    int'(rw));
            chk("MemW",    int'(MemW),    int'(exp_phase == PH_MEMWR));
            chk("PCS",     int'(PCS),     int'(br || (rw && Rd == 4'hF)));
            chk("FlagW",   int'(FlagW),   ex ? int'(am[1:0]) : 0);
            chk("ImmSrc",  int'(ImmSrc),  int'(Op));
            chk("RegSrc",  int'(RegSrc),  int'({Op == 2'b01, Op == 2'b10}));

            case (exp_phase)
                PH_FETCH: begin
                    chk("F_AdrSrc", int'(AdrSrc), 0);
                    chk("F_SrcA", int'(ALUSrcA), 1);
                    chk("F_SrcB", int'(ALUSrcB), 2);
                    chk("F_Res", int'(ResultSrc), 2);
                    chk("F_ALUCtl", int'(ALUControl), 0);
                end
                PH_DECODE: begin
                    chk("D_SrcA", int'(ALUSrcA), 1);
                    chk("D_SrcB", int'(ALUSrcB), 2);
                    chk("D_Res", int'(ResultSrc), 2);
                end
                PH_MEMADR: begin
                    chk("MA_SrcA", int'(ALUSrcA), 0);
                    chk("MA_SrcB", int'(ALUSrcB), 1);
                    chk("MA_ALUCtl", int'(ALUControl), 0);
                end
                PH_MEMRD: begin
                    chk("MR_AdrSrc", int'(AdrSrc), 1);
                    chk("MR_Res", int'(ResultSrc), 0);
                end
                PH_MEMWB: chk("MWB_Res", int'(ResultSrc), 1);
                PH_MEMWR: chk("MW_AdrSrc", int'(AdrSrc), 1);
                PH_EXR, PH_EXI: begin
                    chk("EX_SrcA", int'(ALUSrcA), 0);
                    chk("EX_SrcB", int'(ALUSrcB), (exp_phase == PH_EXI) ? 1 : 0);
                    chk("EX_ALUCtl", int'(ALUControl), int'(am[3:2]));
                end
                PH_ALUWB: chk("AWB_Res", int'(ResultSrc), 0);
                PH_BRANCH: begin
                    chk("B_SrcA", int'(ALUSrcA), 0);
                    chk("B_SrcB", int'(ALUSrcB), 1);
                    chk("B_Res", int'(ResultSrc), 2);
                end
                default: ;
            endcase

            if (IRWrite === 1'b1) begin
                if (started) chk("cycles", cnt, cur_len);
                started = 1'b1;
                cnt = 1;
            end else begin
                cnt++;
            end
        end
    end

    task automatic lit_check(input string tag, input int idx);
        if (tag == "adds" && idx == 2) begin
            chk("adds_ctl", int'(ALUControl), 0);
            chk("adds_flagw", int'(FlagW), 3);
            chk("adds_srcb", int'(ALUSrcB), 1);
        end
        if (tag == "adds" && idx == 3) begin
            chk("adds_regw", int'(RegW), 1);
            chk("adds_pcs", int'(PCS), 0);
        end
        if (tag == "subpc" && idx == 2) begin
            chk("subpc_ctl", int'(ALUControl), 1);
            chk("subpc_flagw", int'(FlagW), 0);
        end
        if (tag == "subpc" && idx == 3) begin
            chk("subpc_regw", int'(RegW), 1);
            chk("subpc_pcs", int'(PCS), 1);
        end
        if (tag == "ldr" && idx == 3) chk("ldr_adrsrc", int'(AdrSrc), 1);
        if (tag == "ldr" && idx == 4) begin
            chk("ldr_res", int'(ResultSrc), 1);
            chk("ldr_regw", int'(RegW), 1);
        end
        if (tag == "str" && idx == 3) begin
            chk("str_memw", int'(MemW), 1);
            chk("str_regw", int'(RegW), 0);
        end
        if (tag == "b" && idx == 2) begin
            chk("b_pcs", int'(PCS), 1);
            chk("b_srcb", int'(ALUSrcB), 1);
            chk("b_res", int'(ResultSrc), 2);
            chk("b_regsrc", int'(RegSrc), 1);
        end
        if (tag == "undef" && idx == 2) begin
            chk("undef_enables", int'({RegW, MemW, IRWrite, NextPC, PCS, FlagW}), 0);
        end
        if (tag == "cmd1010" && idx == 2) chk("cmd1010_flagw", int'(FlagW), 0);
    endtask

    // Caller is just past a clock edge (or mid-cycle) with the DUT in FETCH.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                             input logic [3:0] rd, input string tag, input int exp_len);
        int ph[5];
        int len;
        Op = 2'($urandom);
        Funct = 6'($urandom);
        Rd = 4'($urandom);
        exp_phase = PH_FETCH;
        exp_valid = 1'b1;

        ph[0] = PH_FETCH;
        ph[1] = PH_DECODE;
        ph[3] = PH_FETCH;
        ph[4] = PH_FETCH;
        case (op)
            2'b00: begin ph[2] = funct[5] ? PH_EXI : PH_EXR; ph[3] = PH_ALUWB; len = 4; end
            2'b01: begin
                ph[2] = PH_MEMADR;
                if (funct[0]) begin ph[3] = PH_MEMRD; ph[4] = PH_MEMWB; len = 5; end
                else begin ph[3] = PH_MEMWR; len = 4; end
            end
            2'b10: begin ph[2] = PH_BRANCH; len = 3; end
            default: begin ph[2] = PH_UNK; len = 3; end
        endcase
        if (exp_len != 0) chk({"len_", tag}, len, exp_len);

        @(posedge clk); #1;
        Op = op;
        Funct = funct;
        Rd = rd;
        cur_len = len;
        exp_phase = PH_DECODE;
        for (int i = 2; i < len; i++) begin
            @(posedge clk); #1;
            exp_phase = ph[i];
            if (tag != "") begin
                #2;
                lit_check(tag, i);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] rd;
        logic [3:0] cmds [4];
        cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000; cmds[3] = 4'b1100;

        reset = 1'b1;
        Op = 2'b00;
        Funct = 6'd0;
        Rd = 4'd0;
        #3;
        chk("rst_IRWrite", int'(IRWrite), 1);
        chk("rst_NextPC", int'(NextPC), 1);
        chk("rst_AdrSrc", int'(AdrSrc), 0);
        chk("rst_SrcA", int'(ALUSrcA), 1);
        chk("rst_SrcB", int'(ALUSrcB), 2);
        chk("rst_Res", int'(ResultSrc), 2);
        chk("rst_ALUCtl", int'(ALUControl), 0);
        chk("rst_enables", int'({RegW, MemW, PCS, FlagW}), 0);
        @(posedge clk);
        @(posedge clk); #3;
        reset = 1'b0;

        run_instr(2'b00, 6'b101001, 4'b0011, "adds", 4);
        run_instr(2'b00, 6'b000100, 4'b1111, "subpc", 4);
        run_instr(2'b01, 6'b011001, 4'b0100, "ldr", 5);
        run_instr(2'b01, 6'b011000, 4'b0100, "str", 4);
        run_instr(2'b10, 6'b100110, 4'b0000, "b", 3);
        run_instr(2'b11, 6'b111111, 4'b1111, "undef", 3);
        run_instr(2'b00, 6'b010101, 4'b0010, "cmd1010", 4);

        // Asynchronous reset while in EXECUTER: must return to FETCH before the next edge.
        Op = 2'b00;
        Funct = 6'b000100;
        Rd = 4'b1111;
        exp_phase = PH_FETCH;
        exp_valid = 1'b1;
        @(posedge clk); #1;
        exp_phase = PH_DECODE;
        cur_len = 4;
        @(posedge clk); #1;
        exp_phase = PH_EXR;
        #6;
        exp_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_IRWrite", int'(IRWrite), 1);
        chk("midrst_NextPC", int'(NextPC), 1);
        chk("midrst_RegW", int'(RegW), 0);
        @(posedge clk); #1;
        chk("midrst_RegW_hold", int'(RegW), 0);
        chk("midrst_PCS_hold", int'(PCS), 0);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("postrst_IRWrite", int'(IRWrite), 1);
        chk("postrst_RegW", int'(RegW), 0);

        for (int n = 0; n < 300; n++) begin
            op = 2'($urandom_range(0, 3));
            f = 6'($urandom);
            if (op == 2'b00 && $urandom_range(0, 3) != 0) f[4:1] = cmds[$urandom_range(0, 3)];
            rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            run_instr(op, f, rd, "", 0);
        end

        exp_valid = 1'b0;
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
